shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
- REQ-001: Parameter MSB_FIRST, default 1. 1 = serialize/deserialize MSB first using shift-left (mode 10); 0 = LSB first using shift-right (mode 11).
- REQ-002: clk  input  1  system clock, single clock domain.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: tx_data  input  8  parallel word to serialize.
- REQ-005: tx_valid  input  1  tx_data valid; held until accepted.
- REQ-006: tx_ready  output  1  TX word accepted on clk edge when tx_valid && tx_ready.
- REQ-007: rx_req  input  1  level request to deserialize one 8-bit word; held until rx_gnt.
- REQ-008: rx_gnt  output  1  one-cycle pulse, RX request granted.
- REQ-009: rx_bit  input  1  serial input bit.
- REQ-010: rx_bit_valid  input  1  rx_bit qualifier.
- REQ-011: rx_word  output  8  deserialized word.
- REQ-012: rx_word_valid  output  1  rx_word valid; held until rx_word_ready.
- REQ-013: rx_word_ready  input  1  consumer accepts rx_word.
- REQ-014: ser_o  output  1  serial output bit.
- REQ-015: ser_valid  output  1  ser_o qualifier.
- REQ-016: tx_done  output  1  one-cycle pulse after the last TX bit.
- REQ-017: abort  input  1  cancel any operation in progress.
- REQ-018: sr_mode  output  2  shift register mode: 00 hold, 01 load, 10 left, 11 right.
- REQ-019: sr_par  output  8  shift register parallel load value.
- REQ-020: sr_d  output  1  shift register serial input.
- REQ-021: sr_p  input  8  shift register parallel output. Left shift: next = {P[6:0],D}. Right shift: next = {D,P[7:1]}.

Function
- REQ-022: States are IDLE, TX_SHIFT, RX_SHIFT and RX_DONE. Bit counter is 3 bits. Priority flag prio is 1 bit: 0 = TX preferred, 1 = RX preferred.
- REQ-023: Default outputs in every state: sr_mode=00, sr_par=0, sr_d=0.
- REQ-024: IDLE grants:
  - tx_ready=1 only in IDLE, and only when (!rx_req || prio==0).
  - TX grant is tx_valid && tx_ready.
  - RX grant is rx_req && (!tx_valid || prio==1).
  - Exactly one grant per cycle.
- REQ-025: On TX grant:
  - sr_mode=01 and sr_par=tx_data in the same cycle.
  - Next state TX_SHIFT, counter=0, prio<=1.
- REQ-026: TX_SHIFT:
  - ser_valid=1.
  - ser_o = sr_p[7] if MSB_FIRST, else sr_p[0].
  - sr_mode = 10 if MSB_FIRST, else 11; sr_d=0.
  - Counter increments each cycle.
  - When counter==7: tx_done=1 that cycle, next state IDLE.
  - Exactly 8 ser_valid cycles per word.
- REQ-027: TX latency: first ser_valid is the cycle after acceptance. The next tx_ready is available 9 cycles after acceptance.
- REQ-028: On RX grant:
  - rx_gnt=1, sr_mode=01, sr_par=0.
  - Next state RX_SHIFT, counter=0, prio<=0.
- REQ-029: RX_SHIFT:
  - When rx_bit_valid=1: sr_mode = shift direction per MSB_FIRST, sr_d=rx_bit, counter increments.
  - When rx_bit_valid=0: sr_mode=00.
  - After the 8th valid bit is shifted, next state RX_DONE.
- REQ-030: RX_DONE:
  - rx_word_valid=1, rx_word=sr_p, sr_mode=00.
  - On rx_word_ready=1: next state IDLE.
  - rx_word is 0 in all other states.
- REQ-031: abort=1 in any non-IDLE state:
  - sr_mode=01, sr_par=0 that cycle.
  - Next state IDLE, counter=0.
  - No tx_done; rx_word_valid deasserted next cycle; prio unchanged.
- REQ-032: abort in IDLE takes precedence over grants: no grant that cycle.
- REQ-033: rx_bit_valid outside RX_SHIFT is ignored. tx_valid or rx_req outside IDLE waits.

Reset
- REQ-034: While rst=1, combinational outputs are forced to sr_mode=01, sr_par=0, with tx_ready=0 and rx_gnt=0, so the shift register clears.
- REQ-035: After rst, outputs and registers are:
  - state=IDLE, counter=0, prio=0.
  - ser_valid=0, tx_done=0, rx_word_valid=0, rx_word=0, ser_o=0 (model sr_p=0).
- REQ-036: rst mid-operation discards any word in progress; no tx_done or rx_word_valid follows.

Verification
- REQ-037: The bench SHALL model the shift register per REQ-021 and cover the following scenarios.
- REQ-038: TX, MSB_FIRST=1, tx_data=8'hA5 accepted:
  - ser_o over the next 8 cycles is 1,0,1,0,0,1,0,1.
  - tx_done on the 8th bit; tx_ready high again the next cycle.
- REQ-039: RX, MSB_FIRST=0, bits 1,1,0,0,1,0,1,0 with rx_bit_valid gaps of 2 cycles after bit 3:
  - rx_word=8'h53, rx_word_valid held until rx_word_ready.
- REQ-040: Arbitration, tx_valid and rx_req asserted together from reset:
  - TX granted first, RX granted after tx_done.
  - Next simultaneous request grants TX again, since prio has returned to 0.
- REQ-041: abort on the 4th TX_SHIFT cycle:
  - ser_valid=0 next cycle, no tx_done, sr_mode=01 with sr_par=0 at abort.
  - IDLE the following cycle.
- REQ-042: rst asserted during RX_SHIFT after 5 bits:
  - Next cycle state IDLE, rx_word_valid=0.
  - A fresh RX word completes correctly.
- REQ-043: RX_DONE with rx_word_ready held low 10 cycles:
  - tx_valid=1 not accepted until the cycle after rx_word_ready=1.

Source files
------------

// File: rtl/shift_seq_if.sv
// Bundle of the shift_seq handshake, serial and shift-register signals.
// slave is the sequencer's view; master is the surrounding logic (producer,
// consumer and the external 8-bit shift register).
interface shift_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_req;
  logic       rx_gnt;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic [7:0] rx_word;
  logic       rx_word_valid;
  logic       rx_word_ready;
  logic       ser_o;
  logic       ser_valid;
  logic       tx_done;
  logic       abort;
  logic [1:0] sr_mode;
  logic [7:0] sr_par;
  logic       sr_d;
  logic [7:0] sr_p;

  modport slave (
    input  tx_data, tx_valid, rx_req, rx_bit, rx_bit_valid, rx_word_ready, abort, sr_p,
    output tx_ready, rx_gnt, rx_word, rx_word_valid, ser_o, ser_valid, tx_done,
    output sr_mode, sr_par, sr_d
  );

  modport master (
    output tx_data, tx_valid, rx_req, rx_bit, rx_bit_valid, rx_word_ready, abort, sr_p,
    input  tx_ready, rx_gnt, rx_word, rx_word_valid, ser_o, ser_valid, tx_done,
    input  sr_mode, sr_par, sr_d
  );
endinterface

// File: rtl/shift_seq.sv
// Serializer / deserializer sequencer driving an external 8-bit shift register.
// One engine is shared between TX and RX; a one-bit priority flag alternates
// the winner when both sides request in the same IDLE cycle.
module shift_seq #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        rst,
  shift_seq_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] RX_SHIFT = 2'd2;
  localparam logic [1:0] RX_DONE  = 2'd3;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_RIGHT = 2'b11;
  localparam logic [1:0] MODE_SHIFT = MSB_FIRST ? MODE_LEFT : MODE_RIGHT;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;

  logic       tx_ready;
  logic       rx_gnt;
  logic [7:0] rx_word;
  logic       rx_word_valid;
  logic       ser_o;
  logic       ser_valid;
  logic       tx_done;
  logic [1:0] sr_mode;
  logic [7:0] sr_par;
  logic       sr_d;

  // Next-state and output decode; reset overrides everything with a clear-load.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    prio_d        = prio_q;
    tx_ready      = 1'b0;
    rx_gnt        = 1'b0;
    rx_word       = 8'h00;
    rx_word_valid = 1'b0;
    ser_o         = 1'b0;
    ser_valid     = 1'b0;
    tx_done       = 1'b0;
    sr_mode       = MODE_HOLD;
    sr_par        = 8'h00;
    sr_d          = 1'b0;

    if (rst) begin
      sr_mode = MODE_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          // abort blocks both grants for this cycle
          if (!bus.abort) begin
            tx_ready = !bus.rx_req || !prio_q;
            if (bus.tx_valid && tx_ready) begin
              sr_mode = MODE_LOAD;
              sr_par  = bus.tx_data;
              state_d = TX_SHIFT;
              cnt_d   = 3'd0;
              prio_d  = 1'b1;
            end else if (bus.rx_req && (!bus.tx_valid || prio_q)) begin
              rx_gnt  = 1'b1;
              sr_mode = MODE_LOAD;
              state_d = RX_SHIFT;
              cnt_d   = 3'd0;
              prio_d  = 1'b0;
            end
          end
        end
        TX_SHIFT: begin
          ser_valid = 1'b1;
          ser_o     = MSB_FIRST ? bus.sr_p[7] : bus.sr_p[0];
          if (bus.abort) begin
            sr_mode = MODE_LOAD;
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            sr_mode = MODE_SHIFT;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              tx_done = 1'b1;
              state_d = IDLE;
            end
          end
        end
        RX_SHIFT: begin
          if (bus.abort) begin
            sr_mode = MODE_LOAD;
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else if (bus.rx_bit_valid) begin
            sr_mode = MODE_SHIFT;
            sr_d    = bus.rx_bit;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = RX_DONE;
          end
        end
        RX_DONE: begin
          rx_word_valid = 1'b1;
          rx_word       = bus.sr_p;
          if (bus.abort) begin
            sr_mode = MODE_LOAD;
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else if (bus.rx_word_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, bit counter and arbitration priority registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  assign bus.tx_ready      = tx_ready;
  assign bus.rx_gnt        = rx_gnt;
  assign bus.rx_word       = rx_word;
  assign bus.rx_word_valid = rx_word_valid;
  assign bus.ser_o         = ser_o;
  assign bus.ser_valid     = ser_valid;
  assign bus.tx_done       = tx_done;
  assign bus.sr_mode       = sr_mode;
  assign bus.sr_par        = sr_par;
  assign bus.sr_d          = sr_d;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: one MSB-first and one LSB-first instance, each with its
// own behavioural shift register. Expected serial bits and RX words go into
// queues when stimulus is driven and are popped when the DUT presents them.
module tb_shift_seq;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic       q_bits[$];
  logic [7:0] q_words[$];

  shift_seq_if mif ();
  shift_seq_if lif ();

  shift_seq #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(mif));
  shift_seq #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(lif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift registers: left = {P[6:0],D}, right = {D,P[7:1]}.
  always @(posedge clk) begin
    case (mif.sr_mode)
      2'b01:   mif.sr_p <= mif.sr_par;
      2'b10:   mif.sr_p <= {mif.sr_p[6:0], mif.sr_d};
      2'b11:   mif.sr_p <= {mif.sr_d, mif.sr_p[7:1]};
      default: ;
    endcase
    case (lif.sr_mode)
      2'b01:   lif.sr_p <= lif.sr_par;
      2'b10:   lif.sr_p <= {lif.sr_p[6:0], lif.sr_d};
      2'b11:   lif.sr_p <= {lif.sr_d, lif.sr_p[7:1]};
      default: ;
    endcase
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Call right after the acceptance cycle; scoreboards the 8 serial bits.
  task automatic tx_stream(input logic [7:0] d);
    int   nb;
    int   done_at;
    int   busy;
    logic e;
    for (int i = 7; i >= 0; i--) q_bits.push_back(d[i]);
    nb = 0; done_at = -1; busy = 0;
    for (int c = 0; c < 12 && done_at < 0; c++) begin
      @(negedge clk); mif.tx_valid = 1'b0; #1;
      if (mif.tx_ready === 1'b1 || mif.rx_gnt === 1'b1) busy++;
      if (mif.ser_valid === 1'b1) begin
        nb++;
        n_total++;
        if (q_bits.size() == 0) $display("FAIL tx_extra_bit: got ser_o=%b want none", mif.ser_o);
        else begin
          e = q_bits.pop_front();
          if (mif.ser_o !== e) $display("FAIL tx_bit%0d of %h: got %b want %b", nb, d, mif.ser_o, e);
          else n_pass++;
        end
      end
      if (mif.tx_done === 1'b1) done_at = nb;
    end
    n_total++;
    if (done_at != 8) $display("FAIL tx_done_at_bit: got %0d want 8", done_at); else n_pass++;
    n_total++;
    if (busy != 0) $display("FAIL tx_grant_while_busy: got %0d want 0", busy); else n_pass++;
    q_bits.delete();
  endtask

  // Call right after the RX grant cycle; feeds w MSB first, checks the word.
  task automatic rx_stream(input logic [7:0] w);
    int         k;
    logic [7:0] e;
    q_words.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); mif.rx_req = 1'b0; mif.rx_bit = w[i]; mif.rx_bit_valid = 1'b1;
    end
    @(negedge clk); mif.rx_bit_valid = 1'b0; #1;
    k = 0;
    while (mif.rx_word_valid !== 1'b1 && k < 4) begin @(negedge clk); #1; k++; end
    n_total++;
    if (mif.rx_word_valid !== 1'b1) $display("FAIL rx_word_valid_timeout: got %b want 1", mif.rx_word_valid);
    else n_pass++;
    e = q_words.pop_front();
    n_total++;
    if (mif.rx_word !== e) $display("FAIL rx_word: got %h want %h", mif.rx_word, e); else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; mif.tx_valid = 1'b1; mif.rx_req = 1'b1; mif.tx_data = 8'h77; #1;
    n_total++; if (mif.sr_mode !== 2'b01) $display("FAIL rst_sr_mode: got %b want 01", mif.sr_mode); else n_pass++;
    n_total++; if (mif.sr_par !== 8'h00) $display("FAIL rst_sr_par: got %h want 00", mif.sr_par); else n_pass++;
    n_total++; if (mif.tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b want 0", mif.tx_ready); else n_pass++;
    n_total++; if (mif.rx_gnt !== 1'b0) $display("FAIL rst_rx_gnt: got %b want 0", mif.rx_gnt); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (mif.sr_p !== 8'h00) $display("FAIL rst_sr_p: got %h want 00", mif.sr_p); else n_pass++;
    @(negedge clk); rst = 1'b0; mif.tx_valid = 1'b0; mif.rx_req = 1'b0; #1;
    n_total++; if (mif.ser_valid !== 1'b0) $display("FAIL post_rst_ser_valid: got %b want 0", mif.ser_valid); else n_pass++;
    n_total++; if (mif.ser_o !== 1'b0) $display("FAIL post_rst_ser_o: got %b want 0", mif.ser_o); else n_pass++;
    n_total++; if (mif.tx_done !== 1'b0) $display("FAIL post_rst_tx_done: got %b want 0", mif.tx_done); else n_pass++;
    n_total++; if (mif.rx_word_valid !== 1'b0 || mif.rx_word !== 8'h00)
      $display("FAIL post_rst_rx_word: got %b/%h want 0/00", mif.rx_word_valid, mif.rx_word); else n_pass++;
    n_total++; if (mif.sr_mode !== 2'b00) $display("FAIL post_rst_sr_mode: got %b want 00", mif.sr_mode); else n_pass++;
    n_total++; if (mif.tx_ready !== 1'b1 || lif.tx_ready !== 1'b1)
      $display("FAIL post_rst_tx_ready: got %b%b want 11", mif.tx_ready, lif.tx_ready); else n_pass++;
  endtask

  task automatic test_tx();
    @(negedge clk); mif.tx_data = 8'hA5; mif.tx_valid = 1'b1; #1;
    n_total++; if (mif.tx_ready !== 1'b1) $display("FAIL tx_accept_ready: got %b want 1", mif.tx_ready); else n_pass++;
    n_total++; if (mif.sr_mode !== 2'b01 || mif.sr_par !== 8'hA5)
      $display("FAIL tx_load: got %b/%h want 01/a5", mif.sr_mode, mif.sr_par); else n_pass++;
    tx_stream(8'hA5);
    @(negedge clk); #1;
    n_total++; if (mif.tx_ready !== 1'b1 || mif.ser_valid !== 1'b0)
      $display("FAIL tx_ready_after_done: got %b/%b want 1/0", mif.tx_ready, mif.ser_valid); else n_pass++;
  endtask

  task automatic test_rx_lsb();
    bit         b[8];
    logic [7:0] w;
    logic [7:0] e;
    int         k;
    int         bad;
    b = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) w[i] = b[i];  // first bit ends in bit 0
    q_words.push_back(w);
    @(negedge clk); lif.rx_req = 1'b1; #1;
    n_total++; if (lif.rx_gnt !== 1'b1) $display("FAIL lsb_rx_gnt: got %b want 1", lif.rx_gnt); else n_pass++;
    n_total++; if (lif.sr_mode !== 2'b01 || lif.sr_par !== 8'h00)
      $display("FAIL lsb_rx_clear: got %b/%h want 01/00", lif.sr_mode, lif.sr_par); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); lif.rx_req = 1'b0; lif.rx_bit = b[i]; lif.rx_bit_valid = 1'b1;
      if (i == 2) begin
        repeat (2) begin @(negedge clk); lif.rx_bit_valid = 1'b0; lif.rx_bit = 1'b1; end
      end
    end
    @(negedge clk); lif.rx_bit_valid = 1'b0; #1;
    k = 0;
    while (lif.rx_word_valid !== 1'b1 && k < 4) begin @(negedge clk); #1; k++; end
    e = q_words.pop_front();
    n_total++; if (lif.rx_word_valid !== 1'b1 || lif.rx_word !== e)
      $display("FAIL lsb_rx_word: got %b/%h want 1/%h", lif.rx_word_valid, lif.rx_word, e); else n_pass++;
    bad = 0;
    repeat (3) begin @(negedge clk); #1; if (lif.rx_word_valid !== 1'b1 || lif.rx_word !== e) bad++; end
    n_total++; if (bad != 0) $display("FAIL lsb_rx_hold: got %0d bad cycles want 0", bad); else n_pass++;
    @(negedge clk); lif.rx_word_ready = 1'b1; #1;
    @(negedge clk); lif.rx_word_ready = 1'b0; #1;
    n_total++; if (lif.rx_word_valid !== 1'b0 || lif.rx_word !== 8'h00)
      $display("FAIL lsb_rx_release: got %b/%h want 0/00", lif.rx_word_valid, lif.rx_word); else n_pass++;
  endtask

  task automatic test_arb();
    do_reset();
    @(negedge clk); mif.tx_data = 8'h96; mif.tx_valid = 1'b1; mif.rx_req = 1'b1; #1;
    n_total++; if (mif.tx_ready !== 1'b1 || mif.rx_gnt !== 1'b0)
      $display("FAIL arb_first_tx: got rdy=%b gnt=%b want 1/0", mif.tx_ready, mif.rx_gnt); else n_pass++;
    tx_stream(8'h96);
    @(negedge clk); mif.tx_data = 8'h5A; mif.tx_valid = 1'b1; #1;
    n_total++; if (mif.rx_gnt !== 1'b1 || mif.tx_ready !== 1'b0)
      $display("FAIL arb_then_rx: got gnt=%b rdy=%b want 1/0", mif.rx_gnt, mif.tx_ready); else n_pass++;
    rx_stream(8'hC6);
    mif.rx_word_ready = 1'b1; #1;
    @(negedge clk); mif.rx_word_ready = 1'b0; mif.rx_req = 1'b1; #1;
    n_total++; if (mif.tx_ready !== 1'b1 || mif.rx_gnt !== 1'b0 || mif.sr_par !== 8'h5A)
      $display("FAIL arb_tx_again: got rdy=%b gnt=%b par=%h want 1/0/5a", mif.tx_ready, mif.rx_gnt, mif.sr_par);
    else n_pass++;
    tx_stream(8'h5A);
    @(negedge clk); mif.rx_req = 1'b0; #1;
    n_total++; if (mif.tx_ready !== 1'b1) $display("FAIL arb_idle: got %b want 1", mif.tx_ready); else n_pass++;
  endtask

  task automatic test_abort();
    int bad;
    @(negedge clk); mif.tx_data = 8'hC3; mif.tx_valid = 1'b1; #1;
    n_total++; if (mif.tx_ready !== 1'b1) $display("FAIL abort_accept: got %b want 1", mif.tx_ready); else n_pass++;
    repeat (3) begin @(negedge clk); mif.tx_valid = 1'b0; end
    @(negedge clk); mif.abort = 1'b1; #1;
    n_total++; if (mif.sr_mode !== 2'b01 || mif.sr_par !== 8'h00)
      $display("FAIL abort_clear: got %b/%h want 01/00", mif.sr_mode, mif.sr_par); else n_pass++;
    n_total++; if (mif.tx_done !== 1'b0) $display("FAIL abort_tx_done: got %b want 0", mif.tx_done); else n_pass++;
    @(negedge clk); mif.abort = 1'b0; #1;
    n_total++; if (mif.ser_valid !== 1'b0 || mif.tx_ready !== 1'b1)
      $display("FAIL abort_idle: got sv=%b rdy=%b want 0/1", mif.ser_valid, mif.tx_ready); else n_pass++;
    n_total++; if (mif.sr_p !== 8'h00) $display("FAIL abort_sr_p: got %h want 00", mif.sr_p); else n_pass++;
    bad = 0;
    repeat (8) begin @(negedge clk); #1; if (mif.tx_done !== 1'b0 || mif.ser_valid !== 1'b0) bad++; end
    n_total++; if (bad != 0) $display("FAIL abort_quiet: got %0d bad cycles want 0", bad); else n_pass++;
    @(negedge clk); mif.tx_data = 8'h3C; mif.tx_valid = 1'b1; mif.abort = 1'b1; #1;
    n_total++; if (mif.tx_ready !== 1'b0 || mif.sr_mode !== 2'b00)
      $display("FAIL idle_abort_block: got rdy=%b mode=%b want 0/00", mif.tx_ready, mif.sr_mode); else n_pass++;
    @(negedge clk); mif.abort = 1'b0; #1;
    n_total++; if (mif.tx_ready !== 1'b1 || mif.sr_par !== 8'h3C)
      $display("FAIL idle_abort_then_accept: got rdy=%b par=%h want 1/3c", mif.tx_ready, mif.sr_par); else n_pass++;
    tx_stream(8'h3C);
  endtask

  task automatic test_rst_mid_rx();
    int bad;
    @(negedge clk); mif.rx_req = 1'b1; #1;
    n_total++; if (mif.rx_gnt !== 1'b1) $display("FAIL rstrx_gnt: got %b want 1", mif.rx_gnt); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mif.rx_req = 1'b0; mif.rx_bit = 1'b1; mif.rx_bit_valid = 1'b1;
    end
    @(negedge clk); rst = 1'b1; #1;
    n_total++; if (mif.sr_mode !== 2'b01) $display("FAIL rstrx_forced_load: got %b want 01", mif.sr_mode); else n_pass++;
    @(negedge clk); rst = 1'b0; #1;
    n_total++; if (mif.tx_ready !== 1'b1 || mif.rx_word_valid !== 1'b0 || mif.sr_p !== 8'h00)
      $display("FAIL rstrx_idle: got rdy=%b rwv=%b sr_p=%h want 1/0/00", mif.tx_ready, mif.rx_word_valid, mif.sr_p);
    else n_pass++;
    bad = 0;
    repeat (4) begin @(negedge clk); #1; if (mif.rx_word_valid !== 1'b0 || mif.sr_mode !== 2'b00) bad++; end
    n_total++; if (bad != 0) $display("FAIL rstrx_bits_ignored: got %0d bad cycles want 0", bad); else n_pass++;
    @(negedge clk); mif.rx_bit_valid = 1'b0; mif.rx_req = 1'b1; #1;
    n_total++; if (mif.rx_gnt !== 1'b1) $display("FAIL rstrx_fresh_gnt: got %b want 1", mif.rx_gnt); else n_pass++;
    rx_stream(8'hB4);
    mif.rx_word_ready = 1'b1;
    @(negedge clk); mif.rx_word_ready = 1'b0; #1;
    n_total++; if (mif.rx_word_valid !== 1'b0) $display("FAIL rstrx_release: got %b want 0", mif.rx_word_valid); else n_pass++;
  endtask

  task automatic test_rx_hold();
    int bad;
    @(negedge clk); mif.rx_req = 1'b1; #1;
    n_total++; if (mif.rx_gnt !== 1'b1) $display("FAIL hold_gnt: got %b want 1", mif.rx_gnt); else n_pass++;
    rx_stream(8'h69);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); mif.tx_data = 8'h81; mif.tx_valid = 1'b1; #1;
      if (mif.tx_ready !== 1'b0 || mif.rx_word_valid !== 1'b1 || mif.rx_word !== 8'h69) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL hold_wait: got %0d bad cycles want 0", bad); else n_pass++;
    @(negedge clk); mif.rx_word_ready = 1'b1; #1;
    n_total++; if (mif.tx_ready !== 1'b0) $display("FAIL hold_no_early_accept: got %b want 0", mif.tx_ready); else n_pass++;
    @(negedge clk); mif.rx_word_ready = 1'b0; #1;
    n_total++; if (mif.tx_ready !== 1'b1 || mif.sr_par !== 8'h81)
      $display("FAIL hold_accept_after: got rdy=%b par=%h want 1/81", mif.tx_ready, mif.sr_par); else n_pass++;
    tx_stream(8'h81);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    mif.tx_data = 8'h00; mif.tx_valid = 1'b0; mif.rx_req = 1'b0; mif.rx_bit = 1'b0;
    mif.rx_bit_valid = 1'b0; mif.rx_word_ready = 1'b0; mif.abort = 1'b0;
    lif.tx_data = 8'h00; lif.tx_valid = 1'b0; lif.rx_req = 1'b0; lif.rx_bit = 1'b0;
    lif.rx_bit_valid = 1'b0; lif.rx_word_ready = 1'b0; lif.abort = 1'b0;
    test_reset();
    test_tx();
    test_rx_lsb();
    test_arb();
    test_abort();
    test_rst_mid_rx();
    test_rx_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
